rf_wr_arbiter: RTL and testbench
================================

# rf_wr_arbiter

Shares the single register-file write port among NREQ writeback requesters: ALU writeback, load writeback, and the load-multiple sequencer. Arbitration is round-robin with a valid/ready handshake. A requester can lock the port for a back-to-back burst, which the load-multiple sequencer uses for LM. Outputs are registered and drive the register file's wr_en/wr_addr/wr_data directly.

## Interface
- NREQ, 3: number of requesters (2..4)
- DATA_W, 16: write data width
- ADDR_W, 3: register address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous abort of the current arbitration and lock
- req_valid  in  NREQ  requester i has a write pending
- req_lock  in  NREQ  requester i wants to keep the port after this beat; sampled only on handshake
- req_addr  in  NREQ*ADDR_W  destination register of requester i (slice i)
- req_data  in  NREQ*DATA_W  write data of requester i (slice i)
- req_ready  out  NREQ  one-hot-or-zero; beat i accepted when req_valid[i] & req_ready[i]
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  ADDR_W  register-file write address (registered)
- wr_data  out  DATA_W  register-file write data (registered)
- locked  out  1  high while in LOCK state

## Operation
- States: ARB, LOCK. Internal registers: ptr (round-robin start index), owner (lock holder index).
- ARB: grant goes to the first i with req_valid[i], searching ptr, ptr+1, … mod NREQ. req_ready[grant]=1; all other ready bits are 0. If no requester is valid, all ready bits are 0.
- Handshake in ARB with req_lock[i]=0: ptr <= i+1 mod NREQ; stay in ARB.
- Handshake in ARB with req_lock[i]=1: owner <= i; go to LOCK; ptr is unchanged.
- LOCK: req_ready = one-hot(owner), regardless of req_valid[owner]. Other requesters stall, even while the owner is idle.
- Handshake in LOCK with req_lock[owner]=0: go to ARB; ptr <= owner+1 mod NREQ.
- Handshake in LOCK with req_lock[owner]=1: stay in LOCK.
- Each handshake registers wr_en=1, wr_addr=req_addr[i], wr_data=req_data[i] at the next edge. With no handshake, wr_en=0 and wr_addr/wr_data hold their values.
- flush (priority below rst): all ready bits are 0 in that cycle, so there is no handshake. Next edge: state becomes ARB, wr_en becomes 0, ptr and owner are unchanged.
- locked = (state == LOCK), registered.
- No address filtering: a write to R7 (PC) is forwarded like any other.

## Timing
- req_ready is combinational from req_valid, state, ptr, owner and flush. It never depends on req_lock or req_addr/req_data.
- Latency: handshake at edge N gives wr_en=1 during cycle N+1. The register file commits at edge N+1.
- Throughput: one write per cycle, sustained.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, locked=0, state=ARB, ptr=0, owner=0.
- Reset asserted mid-lock: all of the above take effect immediately, with no extra write.
- Simultaneous requests: exactly one is granted. The others keep valid asserted and data stable until they are accepted.
- Wrap-around: ptr at NREQ-1 advances to 0.
- A requester that deasserts valid before being granted loses nothing. The arbiter keeps no per-requester state.

## Structure
- Shared package rf_pkg holds:
  - REG_W=16, RADDR_W=3, NREGS=8
  - enum arb_state_t {ARB, LOCK}
- One sub-module, rr_pick: combinational round-robin picker with inputs valid[NREQ] and ptr, and outputs grant_onehot and grant_idx.
- rf_wr_arbiter holds only the state/ptr/owner registers and the output registers.

## Test plan
- Single request: req_valid=3'b010, addr=5, data=16'hBEEF → req_ready=3'b010 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=16'hBEEF, ptr=2.
- Round-robin fairness: all three valid for 6 cycles from reset → grant order 0,1,2,0,1,2; wr_en high for 6 consecutive cycles.
- Lock burst: requester 2 sends 4 beats (lock=1,1,1,0) to addr 0..3 while 0 and 1 stay valid → only 2 is granted; locked=1 for 3 cycles after the first beat; then requester 0 is granted (ptr=0).
- Owner idle in LOCK: requester 1 locks, then drops valid for 3 cycles while 0 is valid → req_ready stays 3'b010, wr_en stays 0, and 0 is not granted.
- Flush mid-lock: requester 0 locks, then flush=1 for one cycle with all valid → req_ready=0 that cycle; next cycle state=ARB, wr_en=0; the following grant goes to requester 0 (ptr unchanged).
- Async reset mid-lock: assert rst between edges during a burst → wr_en, locked and wr_addr are immediately 0; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write path.
// REG_W / RADDR_W / NREGS describe the register file. arb_state_t holds the
// write-port arbiter states.
package rf_pkg;

    localparam int REG_W   = 16;
    localparam int RADDR_W = 3;
    localparam int NREGS   = 8;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Bundle between the writeback requesters and the register-file write port.
//   master : requester side. Drives flush and req_*, and sees req_ready and wr_*/locked.
//   slave  : arbiter side.
// req_addr / req_data are packed per requester, where slice i belongs to requester i.
interface rf_wr_arbiter_if
    import rf_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = RADDR_W
);
    logic                     flush;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_lock;
    logic [NREQ*ADDR_W-1:0]   req_addr;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     locked;

    modport master (
        output flush, req_valid, req_lock, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, locked
    );

    modport slave (
        input  flush, req_valid, req_lock, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, locked
    );
endinterface

// File: rtl/rf_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_valid        : request vector
//   i_ptr          : index that gets top priority
//   o_grant_onehot : one-hot grant, or zero when nothing is valid
//   o_grant_idx    : index of the grant (0 when nothing is valid)
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant_onehot,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [IDX_W-1:0] w_idx;

    // Walk from the farthest to the nearest position. The last hit then
    // overwrites earlier ones, so the first valid index at or after ptr wins.
    always_comb begin
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        w_idx          = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IDX_W'((int'(i_ptr) + k) % NREQ);
            if (i_valid[w_idx]) begin
                o_grant_onehot        = '0;
                o_grant_onehot[w_idx] = 1'b1;
                o_grant_idx           = w_idx;
            end
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the single register-file write port among NREQ
// writeback requesters. It uses round-robin arbitration with an optional
// burst lock.
//   clk, rst : clock and async active-high reset
//   rf_bus   : slave side of rf_wr_arbiter_if (requests, ready, registered write port)
//
// state | meaning
// ARB   | round-robin between valid requesters starting at ptr
// LOCK  | port held by owner; all other requesters stall
module rf_wr_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = RADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    rf_wr_arbiter_if.slave rf_bus
);

    localparam int         IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0] ST_ARB  = ARB;
    localparam logic [0:0] ST_LOCK = LOCK;

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_owner;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic [NREQ-1:0]   w_pick_onehot;
    logic [IDX_W-1:0]  w_pick_idx;
    logic [NREQ-1:0]   w_owner_onehot;
    logic [NREQ-1:0]   w_ready;
    logic [IDX_W-1:0]  w_sel;
    logic              w_hs;
    logic              w_sel_lock;
    logic [ADDR_W-1:0] w_addr_arr [NREQ];
    logic [DATA_W-1:0] w_data_arr [NREQ];

    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr_arr[g] = rf_bus.req_addr[g*ADDR_W +: ADDR_W];
        assign w_data_arr[g] = rf_bus.req_data[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_valid        (rf_bus.req_valid),
        .i_ptr          (r_ptr),
        .o_grant_onehot (w_pick_onehot),
        .o_grant_idx    (w_pick_idx)
    );

    assign w_owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

    // The owner keeps ready even while it is idle, so nobody else can slip
    // into the middle of a burst.
    always_comb begin
        w_ready = '0;
        if (!rf_bus.flush) begin
            w_ready = (r_state == ST_LOCK) ? w_owner_onehot : w_pick_onehot;
        end
    end

    assign w_sel      = (r_state == ST_LOCK) ? r_owner : w_pick_idx;
    assign w_hs       = |(w_ready & rf_bus.req_valid);
    assign w_sel_lock = rf_bus.req_lock[w_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_ARB;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_hs;
            if (w_hs) begin
                r_wr_addr <= w_addr_arr[w_sel];
                r_wr_data <= w_data_arr[w_sel];
            end
            if (rf_bus.flush) begin
                r_state <= ST_ARB;
            end else if (w_hs) begin
                if (r_state == ST_ARB) begin
                    if (w_sel_lock) begin
                        r_state <= ST_LOCK;
                        r_owner <= w_sel;
                    end else begin
                        r_ptr <= f_next(w_sel);
                    end
                end else if (!w_sel_lock) begin
                    r_state <= ST_ARB;
                    r_ptr   <= f_next(r_owner);
                end
            end
        end
    end

    assign rf_bus.req_ready = w_ready;
    assign rf_bus.wr_en     = r_wr_en;
    assign rf_bus.wr_addr   = r_wr_addr;
    assign rf_bus.wr_data   = r_wr_data;
    assign rf_bus.locked    = (r_state == ST_LOCK);

endmodule

// File: tb/tb_rf_wr_arbiter.sv
module tb_rf_wr_arbiter;

    logic clk;
    logic rst;

    rf_wr_arbiter_if #(.NREQ(3), .DATA_W(16), .ADDR_W(3)) bus ();

    rf_wr_arbiter #(.NREQ(3), .DATA_W(16), .ADDR_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .rf_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  lock;
        logic        flush;
        logic [8:0]  addr;
        logic [47:0] data;
        logic [2:0]  exp_ready;
        logic        exp_wr_en;
        logic [2:0]  exp_addr;
        logic [15:0] exp_data;
        logic        exp_locked;
    } vec_t;

    vec_t vecs[$];
    int   n_err;
    int   n_chk;

    localparam logic [8:0]  A_STD = {3'd6, 3'd5, 3'd1};
    localparam logic [47:0] D_STD = {16'h2222, 16'hBEEF, 16'h1111};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] v, input logic [2:0] l, input logic f,
                       input logic [8:0] a, input logic [47:0] d,
                       input logic [2:0] er, input logic ee, input logic [2:0] ea,
                       input logic [15:0] ed, input logic el);
        vec_t t;
        t.valid = v; t.lock = l; t.flush = f; t.addr = a; t.data = d;
        t.exp_ready = er; t.exp_wr_en = ee; t.exp_addr = ea; t.exp_data = ed;
        t.exp_locked = el;
        vecs.push_back(t);
    endtask

    // Called at posedge+1: drive reset, check async values, release at a later posedge+1.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.req_valid = '0; bus.req_lock = '0; bus.flush = 1'b0;
        #2;
        chk({tag, " rst wr_en"},   32'(bus.wr_en),   32'd0);
        chk({tag, " rst wr_addr"}, 32'(bus.wr_addr), 32'd0);
        chk({tag, " rst wr_data"}, 32'(bus.wr_data), 32'd0);
        chk({tag, " rst locked"},  32'(bus.locked),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] rr_exp [6];
        logic [2:0] rr_addr [3];
        n_err = 0;
        n_chk = 0;
        rst = 1'b1;
        bus.flush = 1'b0; bus.req_valid = '0; bus.req_lock = '0;
        bus.req_addr = A_STD; bus.req_data = D_STD;

        //   valid   lock    f  addr                     data                                     ready   en  addr  data      lk
        add(3'b010, 3'b000, 0, A_STD,                   D_STD,                                   3'b010, 1, 3'd5, 16'hBEEF, 0);
        add(3'b011, 3'b000, 0, A_STD,                   D_STD,                                   3'b001, 1, 3'd1, 16'h1111, 0);
        add(3'b000, 3'b000, 0, A_STD,                   D_STD,                                   3'b000, 0, 3'd1, 16'h1111, 0);
        add(3'b111, 3'b000, 0, A_STD,                   D_STD,                                   3'b010, 1, 3'd5, 16'hBEEF, 0);
        add(3'b111, 3'b000, 0, {3'd7, 3'd5, 3'd1},      {16'h7777, 16'hBEEF, 16'h1111},          3'b100, 1, 3'd7, 16'h7777, 0);
        add(3'b111, 3'b000, 0, A_STD,                   D_STD,                                   3'b001, 1, 3'd1, 16'h1111, 0);
        add(3'b100, 3'b100, 0, {3'd0, 3'd5, 3'd1},      {16'hA000, 16'hBEEF, 16'h1111},          3'b100, 1, 3'd0, 16'hA000, 1);
        add(3'b111, 3'b100, 0, {3'd1, 3'd5, 3'd1},      {16'hA001, 16'hBEEF, 16'h1111},          3'b100, 1, 3'd1, 16'hA001, 1);
        add(3'b111, 3'b100, 0, {3'd2, 3'd5, 3'd1},      {16'hA002, 16'hBEEF, 16'h1111},          3'b100, 1, 3'd2, 16'hA002, 1);
        add(3'b111, 3'b000, 0, {3'd3, 3'd5, 3'd1},      {16'hA003, 16'hBEEF, 16'h1111},          3'b100, 1, 3'd3, 16'hA003, 0);
        add(3'b111, 3'b000, 0, A_STD,                   D_STD,                                   3'b001, 1, 3'd1, 16'h1111, 0);
        add(3'b010, 3'b010, 0, A_STD,                   D_STD,                                   3'b010, 1, 3'd5, 16'hBEEF, 1);
        add(3'b001, 3'b000, 0, A_STD,                   D_STD,                                   3'b010, 0, 3'd5, 16'hBEEF, 1);
        add(3'b001, 3'b000, 0, A_STD,                   D_STD,                                   3'b010, 0, 3'd5, 16'hBEEF, 1);
        add(3'b001, 3'b000, 0, A_STD,                   D_STD,                                   3'b010, 0, 3'd5, 16'hBEEF, 1);
        add(3'b011, 3'b000, 0, A_STD,                   D_STD,                                   3'b010, 1, 3'd5, 16'hBEEF, 0);
        add(3'b100, 3'b000, 0, A_STD,                   D_STD,                                   3'b100, 1, 3'd6, 16'h2222, 0);
        add(3'b001, 3'b001, 0, A_STD,                   D_STD,                                   3'b001, 1, 3'd1, 16'h1111, 1);
        add(3'b111, 3'b111, 1, A_STD,                   D_STD,                                   3'b000, 0, 3'd1, 16'h1111, 0);
        add(3'b111, 3'b000, 0, A_STD,                   D_STD,                                   3'b001, 1, 3'd1, 16'h1111, 0);

        @(posedge clk); #1;
        do_reset("init");

        foreach (vecs[i]) begin
            bus.req_valid = vecs[i].valid;
            bus.req_lock  = vecs[i].lock;
            bus.flush     = vecs[i].flush;
            bus.req_addr  = vecs[i].addr;
            bus.req_data  = vecs[i].data;
            #3;
            chk($sformatf("row%0d ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            @(posedge clk); #1;
            chk($sformatf("row%0d wr_en", i),   32'(bus.wr_en),   32'(vecs[i].exp_wr_en));
            chk($sformatf("row%0d wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("row%0d wr_data", i), 32'(bus.wr_data), 32'(vecs[i].exp_data));
            chk($sformatf("row%0d locked", i),  32'(bus.locked),  32'(vecs[i].exp_locked));
        end
        bus.flush = 1'b0;

        // Round-robin from reset: all valid, grant order 0,1,2,0,1,2.
        do_reset("rr");
        rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rr_addr = '{3'd1, 3'd5, 3'd6};
        bus.req_addr = A_STD; bus.req_data = D_STD;
        bus.req_valid = 3'b111; bus.req_lock = 3'b000;
        for (int c = 0; c < 6; c++) begin
            #3;
            chk($sformatf("rr%0d ready", c), 32'(bus.req_ready), 32'(rr_exp[c]));
            @(posedge clk); #1;
            chk($sformatf("rr%0d wr_en", c),   32'(bus.wr_en),   32'd1);
            chk($sformatf("rr%0d wr_addr", c), 32'(bus.wr_addr), 32'(rr_addr[c % 3]));
        end

        // Async reset in the middle of a lock burst from requester 1.
        bus.req_valid = 3'b010; bus.req_lock = 3'b010;
        @(posedge clk); #1;
        chk("arst beat1 locked",  32'(bus.locked),  32'd1);
        chk("arst beat1 wr_addr", 32'(bus.wr_addr), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst wr_en now",   32'(bus.wr_en),   32'd0);
        chk("arst locked now",  32'(bus.locked),  32'd0);
        chk("arst wr_addr now", 32'(bus.wr_addr), 32'd0);
        @(posedge clk); #1;
        chk("arst no extra write", 32'(bus.wr_en), 32'd0);
        rst = 1'b0;
        bus.req_valid = 3'b111; bus.req_lock = 3'b000;
        #3;
        chk("arst first ready", 32'(bus.req_ready), 32'b001);
        @(posedge clk); #1;
        chk("arst first wr_en",   32'(bus.wr_en),   32'd1);
        chk("arst first wr_addr", 32'(bus.wr_addr), 32'd1);

        bus.req_valid = '0;
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
